// File: rtl/alu_unit.sv
// ---------------------------------------------------------------------------
// alu_unit : multi-cycle integer ALU.
//   Single-cycle ops (ADD, SUB, ADDR, AND, OR, SWAP, illegal) finish on the
//   edge after start. MUL is an unsigned shift-add multiplier that retires
//   one bit per cycle. DIV is an unsigned restoring divider that also
//   retires one bit per cycle.
//
// Optional build macro: ALU_DIV_EN
//   When defined, the DIV state and the divider datapath are built.
//   When undefined, code 0011 is handled as an illegal code.
//
// Parameters
//   WIDTH       operand width and result-half width in bits (default 16)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   start       request; sampled only while busy = 0
//   operation   4-bit operation code
//   opA, opB    operands; sampled together with start
//   busy        high while a MUL or DIV is in flight
//   done        one-cycle pulse when the results become valid
//   resultLo    low result half (sum / product low / quotient)
//   resultHi    high result half (product high / remainder)
//   zero        resultLo == 0, updated together with done
//   overflow    signed overflow of ADD/SUB
//   divByZero   DIV with opB = 0
//   illegalOp   unsupported operation code
// ---------------------------------------------------------------------------
module alu_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resultLo,
    output logic [WIDTH-1:0] resultHi,
    output logic             zero,
    output logic             overflow,
    output logic             divByZero,
    output logic             illegalOp
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_SWAP = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_ADDR = 4'b1000;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIV  = 4'b0011;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL
`ifdef ALU_DIV_EN
        , S_DIV
`endif
    } state_t;

    state_t             r_state;
    state_t             w_next;

    // Working registers shared by the multiplier and the divider.
    // MUL: {r_hi,r_lo} is the partial product with the multiplier in r_lo.
    // DIV: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_count;

    logic               w_last;
    logic               w_accept;
    logic               w_load;
    logic               w_fin;
    logic [WIDTH-1:0]   w_fin_lo;
    logic [WIDTH-1:0]   w_fin_hi;
    logic               w_fin_ovf;
    logic               w_fin_dbz;
    logic               w_fin_ill;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;

    logic [WIDTH-1:0]   w_add;
    logic [WIDTH-1:0]   w_sub;
    logic               w_add_ovf;
    logic               w_sub_ovf;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;

    assign w_add     = opA + opB;
    assign w_sub     = opA - opB;
    assign w_add_ovf = (opA[WIDTH-1] == opB[WIDTH-1]) && (w_add[WIDTH-1] != opA[WIDTH-1]);
    assign w_sub_ovf = (opA[WIDTH-1] != opB[WIDTH-1]) && (w_sub[WIDTH-1] != opA[WIDTH-1]);

    // Shift-add step: conditionally add the multiplicand into the upper half,
    // then shift the whole (2*WIDTH+1)-bit value right by one.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

`ifdef ALU_DIV_EN
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;

    // Restoring step: the remainder is always below the divisor, so the
    // shifted value fits in WIDTH+1 bits; a set MSB of the difference means
    // the trial subtraction went negative and is discarded.
    assign w_div_sh   = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_b};
    assign w_div_ok   = ~w_div_diff[WIDTH];
    assign w_div_hi   = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
    assign w_div_lo   = {r_lo[WIDTH-2:0], w_div_ok};
`endif

    assign w_last = (r_count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        w_accept  = 1'b0;
        w_load    = 1'b0;
        w_fin     = 1'b0;
        w_fin_lo  = '0;
        w_fin_hi  = '0;
        w_fin_ovf = 1'b0;
        w_fin_dbz = 1'b0;
        w_fin_ill = 1'b0;
        w_step_hi = r_hi;
        w_step_lo = r_lo;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    case (operation)
                        OP_ADD:  begin w_fin = 1'b1; w_fin_lo = w_add; w_fin_ovf = w_add_ovf; end
                        OP_SUB:  begin w_fin = 1'b1; w_fin_lo = w_sub; w_fin_ovf = w_sub_ovf; end
                        OP_ADDR: begin w_fin = 1'b1; w_fin_lo = w_add; end
                        OP_AND:  begin w_fin = 1'b1; w_fin_lo = opA & opB; end
                        OP_OR:   begin w_fin = 1'b1; w_fin_lo = opA | opB; end
                        OP_SWAP: begin w_fin = 1'b1; w_fin_lo = opB; w_fin_hi = opA; end
                        OP_MUL:  begin w_load = 1'b1; w_next = S_MUL; end
`ifdef ALU_DIV_EN
                        OP_DIV: begin
                            if (opB == '0) begin
                                w_fin     = 1'b1;
                                w_fin_lo  = '1;
                                w_fin_hi  = opA;
                                w_fin_dbz = 1'b1;
                            end else begin
                                w_load = 1'b1;
                                w_next = S_DIV;
                            end
                        end
`endif
                        default: begin w_fin = 1'b1; w_fin_ill = 1'b1; end
                    endcase
                end
            end
            S_MUL: begin
                busy      = 1'b1;
                w_step_hi = w_mul_hi;
                w_step_lo = w_mul_lo;
                if (w_last) begin
                    w_fin    = 1'b1;
                    w_fin_lo = w_mul_lo;
                    w_fin_hi = w_mul_hi;
                    w_next   = S_IDLE;
                end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                busy      = 1'b1;
                w_step_hi = w_div_hi;
                w_step_lo = w_div_lo;
                if (w_last) begin
                    w_fin    = 1'b1;
                    w_fin_lo = w_div_lo;
                    w_fin_hi = w_div_hi;
                    w_next   = S_IDLE;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_count   <= '0;
            done      <= 1'b0;
            resultLo  <= '0;
            resultHi  <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            divByZero <= 1'b0;
            illegalOp <= 1'b0;
        end else begin
            done <= w_fin;
            if (w_load) begin
                r_hi    <= '0;
                r_lo    <= opA;
                r_b     <= opB;
                r_count <= '0;
            end else if (busy) begin
                r_hi    <= w_step_hi;
                r_lo    <= w_step_lo;
                r_count <= r_count + 1'b1;
            end
            if (w_accept) begin
                divByZero <= 1'b0;
                illegalOp <= 1'b0;
            end
            // Completion overrides the start-time clear for single-cycle ops.
            if (w_fin) begin
                resultLo  <= w_fin_lo;
                resultHi  <= w_fin_hi;
                zero      <= (w_fin_lo == '0);
                overflow  <= w_fin_ovf;
                divByZero <= w_fin_dbz;
                illegalOp <= w_fin_ill;
            end
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_unit : directed self-checking bench for alu_unit (WIDTH = 16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   operation;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         busy;
    logic         done;
    logic [W-1:0] resultLo;
    logic [W-1:0] resultHi;
    logic         zero;
    logic         overflow;
    logic         divByZero;
    logic         illegalOp;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int nbusy;

    alu_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .operation (operation),
        .opA       (opA),
        .opB       (opB),
        .busy      (busy),
        .done      (done),
        .resultLo  (resultLo),
        .resultHi  (resultHi),
        .zero      (zero),
        .overflow  (overflow),
        .divByZero (divByZero),
        .illegalOp (illegalOp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge. Issues start immediately, then walks falling
    // edges until done (bounded). Operands are scrambled while in flight and
    // an optional competing start is raised at cycle 'inj'.
    task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int inj, output int l, output int nb);
        start     = 1'b1;
        operation = op;
        opA       = a;
        opB       = b;
        l  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            l++;
            if (busy) nb++;
            opA = 16'h5555;
            opB = 16'h00AA;
            if (inj != 0 && l == inj) begin
                start     = 1'b1;
                operation = 4'b0000;
            end else begin
                start = 1'b0;
            end
        end while (!done && l < 40);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        operation = 4'b0000;
        opA       = '0;
        opB       = '0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_lo", 32'(resultLo), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // ADD with signed overflow
        run(4'b0000, 16'h7FFF, 16'h0001, 0, lat, nbusy);
        chk("add_lat", 32'(lat), 32'd1);
        chk("add_lo", 32'(resultLo), 32'h8000);
        chk("add_hi", 32'(resultHi), 32'h0);
        chk("add_ovf", 32'(overflow), 32'h1);
        chk("add_zero", 32'(zero), 32'h0);
        @(negedge clk);
        chk("add_done_pulse", 32'(done), 32'h0);
        chk("add_hold_lo", 32'(resultLo), 32'h8000);

        // SUB overflow, then SUB to zero
        run(4'b0001, 16'h8000, 16'h0001, 0, lat, nbusy);
        chk("sub_lo", 32'(resultLo), 32'h7FFF);
        chk("sub_ovf", 32'(overflow), 32'h1);
        run(4'b0001, 16'h0005, 16'h0005, 0, lat, nbusy);
        chk("sub0_lo", 32'(resultLo), 32'h0);
        chk("sub0_zero", 32'(zero), 32'h1);
        chk("sub0_ovf", 32'(overflow), 32'h0);

        // ADDR never flags overflow
        run(4'b1000, 16'h7FFF, 16'h0001, 0, lat, nbusy);
        chk("addr_lo", 32'(resultLo), 32'h8000);
        chk("addr_ovf", 32'(overflow), 32'h0);

        run(4'b0100, 16'hF0F0, 16'h3C3C, 0, lat, nbusy);
        chk("and_lo", 32'(resultLo), 32'h3030);
        run(4'b0111, 16'hF0F0, 16'h0F0F, 0, lat, nbusy);
        chk("or_lo", 32'(resultLo), 32'hFFFF);

        // MUL with a competing start at N+5 that must be ignored
        run(4'b0010, 16'hFFFF, 16'hFFFF, 5, lat, nbusy);
        chk("mul_lat", 32'(lat), 32'd17);
        chk("mul_busy_cycles", 32'(nbusy), 32'd16);
        chk("mul_busy_at_done", 32'(busy), 32'h0);
        chk("mul_hi", 32'(resultHi), 32'hFFFE);
        chk("mul_lo", 32'(resultLo), 32'h0001);

        // Start in the same cycle as done is accepted
        run(4'b0000, 16'h0002, 16'h0003, 0, lat, nbusy);
        chk("b2b_lat", 32'(lat), 32'd1);
        chk("b2b_lo", 32'(resultLo), 32'h0005);
        chk("b2b_hi", 32'(resultHi), 32'h0);

`ifdef ALU_DIV_EN
        run(4'b0011, 16'd100, 16'd7, 0, lat, nbusy);
        chk("div_lat", 32'(lat), 32'd17);
        chk("div_q", 32'(resultLo), 32'd14);
        chk("div_r", 32'(resultHi), 32'd2);
        run(4'b0011, 16'd5, 16'd0, 0, lat, nbusy);
        chk("div0_lat", 32'(lat), 32'd1);
        chk("div0_lo", 32'(resultLo), 32'hFFFF);
        chk("div0_hi", 32'(resultHi), 32'h0005);
        chk("div0_flag", 32'(divByZero), 32'h1);
`else
        run(4'b0011, 16'd100, 16'd7, 0, lat, nbusy);
        chk("div_ill_lat", 32'(lat), 32'd1);
        chk("div_ill_flag", 32'(illegalOp), 32'h1);
        chk("div_ill_lo", 32'(resultLo), 32'h0);
`endif

        run(4'b0101, 16'h1234, 16'hABCD, 0, lat, nbusy);
        chk("swap_lo", 32'(resultLo), 32'hABCD);
        chk("swap_hi", 32'(resultHi), 32'h1234);
        chk("swap_dbz_clr", 32'(divByZero), 32'h0);
        chk("swap_ill_clr", 32'(illegalOp), 32'h0);

        run(4'b0110, 16'h1111, 16'h2222, 0, lat, nbusy);
        chk("ill_lat", 32'(lat), 32'd1);
        chk("ill_flag", 32'(illegalOp), 32'h1);
        chk("ill_lo", 32'(resultLo), 32'h0);
        chk("ill_hi", 32'(resultHi), 32'h0);
        chk("ill_zero", 32'(zero), 32'h1);

        // Load nonzero results, then abort a MUL with reset at N+8
        run(4'b0101, 16'h1234, 16'hABCD, 0, lat, nbusy);
        start     = 1'b1;
        operation = 4'b0010;
        opA       = 16'h0003;
        opB       = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        chk("rmul_busy", 32'(busy), 32'h1);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rmid_busy", 32'(busy), 32'h0);
        chk("rmid_done", 32'(done), 32'h0);
        chk("rmid_lo", 32'(resultLo), 32'h0);
        chk("rmid_hi", 32'(resultHi), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) nbusy++;
        end
        chk("rabort_no_done", 32'(nbusy), 32'd0);

        run(4'b0000, 16'h0002, 16'h0003, 0, lat, nbusy);
        chk("post_rst_lat", 32'(lat), 32'd1);
        chk("post_rst_lo", 32'(resultLo), 32'h0005);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
